// File: rtl/baud_gen_frac.sv
// Fractional-N baud tick generator: a phase accumulator produces the RX oversample
// enable on each carry, and every OVERSAMPLE-th carry also produces the TX bit enable.
module baud_gen_frac #(
  parameter int unsigned CLOCK_FREQ = 62500000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned ACC_WIDTH  = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 inc_wr,
  input  logic [ACC_WIDTH-1:0] inc_data,
  output logic [ACC_WIDTH-1:0] inc_cur,
  input  logic                 tx_restart,
  output logic                 rxclk_en,
  output logic                 txclk_en
);

  localparam int unsigned OS_W = $clog2(OVERSAMPLE);

  // Rounded reset increment, evaluated entirely in 64-bit arithmetic.
  localparam logic [63:0] INC_NUM     = (64'(BAUD_RATE) * 64'(OVERSAMPLE)) << ACC_WIDTH;
  localparam logic [63:0] INC_ROUNDED = (INC_NUM + 64'(CLOCK_FREQ / 32'd2)) / 64'(CLOCK_FREQ);
  localparam logic [ACC_WIDTH-1:0] DEFAULT_INC = INC_ROUNDED[ACC_WIDTH-1:0];
  localparam logic [OS_W-1:0]      OS_LAST     = OS_W'(OVERSAMPLE - 32'd1);

  if (INC_ROUNDED == 64'd0 || INC_ROUNDED >= (64'd1 << ACC_WIDTH)) begin : g_bad_inc
    $error("baud_gen_frac: DEFAULT_INC out of range for ACC_WIDTH");
  end
  if (OVERSAMPLE < 32'd4 || OVERSAMPLE > 32'd64 || (OVERSAMPLE & (OVERSAMPLE - 32'd1)) != 32'd0) begin : g_bad_os
    $error("baud_gen_frac: OVERSAMPLE must be a power of two in 4..64");
  end
  if (ACC_WIDTH < 32'd16 || ACC_WIDTH > 32'd32) begin : g_bad_w
    $error("baud_gen_frac: ACC_WIDTH must be in 16..32");
  end

  logic [ACC_WIDTH-1:0] r_acc;
  logic [ACC_WIDTH-1:0] r_inc;
  logic [OS_W-1:0]      r_os_cnt;
  logic                 r_rxclk_en;
  logic                 r_txclk_en;

  logic [ACC_WIDTH:0]   w_sum;
  logic                 w_carry;
  logic [OS_W-1:0]      w_os_next;

  assign w_sum     = {1'b0, r_acc} + {1'b0, r_inc};
  assign w_carry   = w_sum[ACC_WIDTH];
  assign w_os_next = (r_os_cnt == OS_LAST) ? OS_W'(0) : (r_os_cnt + OS_W'(1));

  // Increment register; a write never disturbs the accumulator, so phase stays continuous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inc <= DEFAULT_INC;
    end else if (inc_wr) begin
      r_inc <= inc_data;
    end else begin
      r_inc <= r_inc;
    end
  end

  // Phase accumulator, oversample counter and registered tick outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= '0;
      r_os_cnt   <= '0;
      r_rxclk_en <= 1'b0;
      r_txclk_en <= 1'b0;
    end else if (tx_restart) begin
      r_acc      <= '0;
      r_os_cnt   <= '0;
      r_rxclk_en <= 1'b0;
      r_txclk_en <= 1'b0;
    end else if (enable) begin
      r_acc      <= w_sum[ACC_WIDTH-1:0];
      r_rxclk_en <= w_carry;
      r_txclk_en <= w_carry & (r_os_cnt == OS_LAST);
      if (w_carry) begin
        r_os_cnt <= w_os_next;
      end else begin
        r_os_cnt <= r_os_cnt;
      end
    end else begin
      r_acc      <= r_acc;
      r_os_cnt   <= r_os_cnt;
      r_rxclk_en <= 1'b0;
      r_txclk_en <= 1'b0;
    end
  end

  assign inc_cur  = r_inc;
  assign rxclk_en = r_rxclk_en;
  assign txclk_en = r_txclk_en;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: a per-cycle scoreboard of expected outputs plus directed
// closed-form checks of tick counts, spacing, restart alignment, hold and async reset.
module tb_baud_gen_frac;

  localparam int W  = 24;
  localparam int OS = 16;
  localparam logic [W-1:0] DEF_INC = 24'd494780;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic         inc_wr = 1'b0;
  logic [W-1:0] inc_data = '0;
  logic         tx_restart = 1'b0;
  logic [W-1:0] inc_cur;
  logic         rxclk_en;
  logic         txclk_en;

  baud_gen_frac #(
    .CLOCK_FREQ(62500000), .BAUD_RATE(115200), .OVERSAMPLE(OS), .ACC_WIDTH(W)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .inc_wr(inc_wr), .inc_data(inc_data),
    .inc_cur(inc_cur), .tx_restart(tx_restart), .rxclk_en(rxclk_en), .txclk_en(txclk_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] inc;
    logic         rx;
    logic         tx;
  } exp_t;

  exp_t   sb[$];
  int     vectors = 0;
  int     miscompares = 0;
  longint m_acc;
  int     m_os;
  logic [W-1:0] m_inc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_os  = 0;
    m_inc = DEF_INC;
    sb.delete();
  endtask

  // Predict the edge outcome from current inputs, push it, clock, then pop and compare.
  task automatic step();
    exp_t         e;
    exp_t         got;
    logic [W-1:0] nxt_inc;
    longint       s;
    nxt_inc = m_inc;
    if (inc_wr) nxt_inc = inc_data;
    if (tx_restart) begin
      m_acc = 0; m_os = 0; e.rx = 1'b0; e.tx = 1'b0;
    end else if (enable) begin
      s     = m_acc + longint'(m_inc);
      e.rx  = (s >= (longint'(1) << W));
      e.tx  = e.rx && (m_os == OS - 1);
      m_acc = s % (longint'(1) << W);
      if (e.rx) m_os = (m_os + 1) % OS;
    end else begin
      e.rx = 1'b0; e.tx = 1'b0;
    end
    m_inc = nxt_inc;
    e.inc = nxt_inc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("step", {inc_cur, rxclk_en, txclk_en}, {got.inc, got.rx, got.tx});
  endtask

  initial begin
    int rxn, txn, orphan_tx, last, sp, min_sp, max_sp, pulses, first_rx, first_tx, n;
    logic er, et;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_inc_cur", inc_cur, DEF_INC);
    check("rst_rx", rxclk_en, 1'b0);
    check("rst_tx", txclk_en, 1'b0);
    #3 rst = 1'b0;
    model_reset();
    enable = 1'b1;

    // Default increment: tick count and spacing from a restarted phase
    tx_restart = 1'b1; step(); tx_restart = 1'b0;
    rxn = 0; txn = 0; orphan_tx = 0; last = -1; min_sp = 1000; max_sp = 0;
    for (int k = 1; k <= 20000; k++) begin
      step();
      if (txclk_en && !rxclk_en) orphan_tx++;
      if (txclk_en) txn++;
      if (rxclk_en) begin
        rxn++;
        if (last >= 0) begin
          sp = k - last;
          if (sp < min_sp) min_sp = sp;
          if (sp > max_sp) max_sp = sp;
        end
        last = k;
      end
    end
    check("def_rx_count", rxn, (64'd20000 * 64'd494780) >> 24);
    check("def_tx_count", txn, ((64'd20000 * 64'd494780) >> 24) / 64'd16);
    check("def_min_spacing", min_sp, 33);
    check("def_max_spacing", max_sp, 34);
    check("def_tx_without_rx", orphan_tx, 0);

    // inc = 0x800000 then restart: rx every 2nd cycle, tx every 32nd
    inc_data = 24'h800000; inc_wr = 1'b1; step(); inc_wr = 1'b0;
    tx_restart = 1'b1; step(); tx_restart = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      step();
      er = (k % 2 == 0); et = (k % 32 == 0);
      check("half_pattern", {rxclk_en, txclk_en}, {er, et});
    end

    // inc write coincident with restart: new inc used, rx at 4, tx at 64
    inc_data = 24'h400000; inc_wr = 1'b1; tx_restart = 1'b1; step();
    inc_wr = 1'b0; tx_restart = 1'b0;
    check("coinc_inc_cur", inc_cur, 24'h400000);
    for (int k = 1; k <= 64; k++) begin
      step();
      er = (k % 4 == 0); et = (k == 64);
      check("quarter_pattern", {rxclk_en, txclk_en}, {er, et});
    end

    // Hold mid-bit for 100 cycles, then resume from the held phase
    step(); step();
    enable = 1'b0; pulses = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (rxclk_en || txclk_en) pulses++;
    end
    check("hold_pulses", pulses, 0);
    enable = 1'b1; first_rx = 0; first_tx = 0;
    for (int k = 1; k <= 70; k++) begin
      step();
      if (rxclk_en && first_rx == 0) first_rx = k;
      if (txclk_en && first_tx == 0) first_tx = k;
    end
    check("resume_first_rx", first_rx, 2);
    check("resume_first_tx", first_tx, 62);

    // Zero increment freezes; 0x800000 restores the 2-cycle cadence
    inc_data = '0; inc_wr = 1'b1; step(); inc_wr = 1'b0;
    pulses = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (rxclk_en) pulses++;
    end
    check("zero_inc_pulses", pulses, 0);
    inc_data = 24'h800000; inc_wr = 1'b1; step(); inc_wr = 1'b0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (rxclk_en) pulses++;
    end
    check("restored_cadence", pulses, 10);

    // Asynchronous reset between edges while rxclk_en is high
    n = 0;
    while (rxclk_en !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check("wait_rx_high", rxclk_en, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_rx", rxclk_en, 1'b0);
    check("async_rst_tx", txclk_en, 1'b0);
    check("async_rst_inc", inc_cur, DEF_INC);
    #3 rst = 1'b0;
    model_reset();
    first_rx = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (rxclk_en && first_rx == 0) first_rx = k;
    end
    check("post_rst_first_rx", first_rx, 34);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/baud_gen_frac.md
Name: baud_gen_frac

Overview:
Fractional-N baud tick generator for the UART blocks. It replaces the fixed integer divider with a runtime-programmable phase accumulator, so there is no integer-truncation baud error. It produces an RX oversample enable and a TX bit enable derived from it, with enable gating and a TX phase restart. It sits between the CPU-visible UART control register (increment write) and the uart_rx/uart_tx engines.

Parameters:
CLOCK_FREQ, 62500000, system clock frequency in Hz.
BAUD_RATE, 115200, baud rate used to compute the reset increment.
OVERSAMPLE, 16, RX ticks per TX bit; power of two, 4..64.
ACC_WIDTH, 24, phase accumulator width in bits, 16..32.
DEFAULT_INC, round(BAUD_RATE*OVERSAMPLE*2^ACC_WIDTH/CLOCK_FREQ), reset increment.
- Computed in 64-bit arithmetic.
- Elaboration must fail if the result is 0 or >= 2^ACC_WIDTH.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  asynchronous, active-high reset.
enable  input  1  1 = generator runs; 0 = accumulator and counter hold.
inc_wr  input  1  one-cycle strobe that loads inc_data.
inc_data  input  ACC_WIDTH  new phase increment.
inc_cur  output  ACC_WIDTH  currently active increment.
tx_restart  input  1  one-cycle strobe that realigns TX bit phase.
rxclk_en  output  1  one-cycle pulse at BAUD*OVERSAMPLE average rate.
txclk_en  output  1  one-cycle pulse at BAUD average rate.

Behaviour:
- Reset (async assert, sync release effective on first clk edge after deassert):
  - acc=0, os_cnt=0, inc_cur=DEFAULT_INC, rxclk_en=0, txclk_en=0.
- State: acc[ACC_WIDTH-1:0]; os_cnt[log2(OVERSAMPLE)-1:0]; inc register driving inc_cur. All outputs are registered.
- Per-cycle priority: rst > tx_restart > normal step. inc_wr is independent of both and may coincide with either.
- inc_wr: inc register <= inc_data at the edge.
  - The new value is used by the step in the following cycle.
  - acc is not cleared, so phase is continuous.
  - inc_data=0 is legal and stops ticks while acc holds its value.
- Normal step (enable=1, no tx_restart): {carry, acc} <= acc + inc (ACC_WIDTH+1-bit add; wrap is modulo 2^ACC_WIDTH).
  - rxclk_en <= carry.
  - If carry: os_cnt <= os_cnt+1, wrapping at OVERSAMPLE-1 -> 0.
  - txclk_en <= carry & (os_cnt == OVERSAMPLE-1).
  - txclk_en is therefore always coincident with rxclk_en. There is at most one carry per cycle.
- enable=0: acc and os_cnt hold; rxclk_en<=0, txclk_en<=0. Re-enabling resumes from the held phase, with no burst of ticks.
- tx_restart: acc<=0, os_cnt<=0, rxclk_en<=0, txclk_en<=0 in that cycle, regardless of enable.
  - The first txclk_en follows exactly OVERSAMPLE rx ticks later.
- Tick count: after N enabled steps from acc=0, rx ticks = floor(N*inc/2^ACC_WIDTH) and tx ticks = floor(rx ticks/OVERSAMPLE).
- Pulse spacing: rx spacing jitters by at most 1 cycle between floor(2^W/inc) and ceil(2^W/inc). There is no long-term drift.
- Latency: a carry on step k gives rxclk_en high at the output in the cycle after edge k. Each pulse is exactly one cycle wide.
- Reset mid-operation clears everything immediately and asynchronously; outputs drop in the same cycle reset asserts.

Test Plan:
- Reset defaults (W=24, 62.5 MHz, 115200, OS=16):
  - inc_cur=494780 (0x78CBC) after reset.
  - Over 2^24 enabled cycles: exactly 494780 rxclk_en and 30923 txclk_en.
  - rx spacing is always 33 or 34 cycles.
- inc_wr inc_data=0x800000, then tx_restart:
  - rxclk_en high on every 2nd cycle starting 2 cycles after restart.
  - txclk_en on every 32nd cycle, always coincident with an rxclk_en.
- inc_wr and tx_restart asserted in the same cycle (inc 0x400000):
  - New inc is active; first rxclk_en 4 cycles later.
  - First txclk_en 64 cycles later.
- enable=0 for 100 cycles mid-bit at inc=0x400000:
  - No pulses during the hold; acc and os_cnt are unchanged.
  - After re-enable, the remaining spacing to the next tick continues exactly where it left off.
- inc_wr 0 while running: pulses stop and acc freezes. inc_wr 0x800000 restores the 2-cycle rx cadence, continuing from the old phase.
- Assert rst asynchronously between edges while rxclk_en=1:
  - rxclk_en/txclk_en drop immediately; inc_cur returns to 494780.
  - After release, counting restarts from acc=0.
